// File: rtl/rtc_alarm_bank.sv
// Multi-channel RTC alarm engine: masked BCD compare, one-shot/repeat FSMs, hit counters, W1C interrupt status.
// Hit pulse 2 cycles after inc_time_s, irq 1 later; reg access acked 1 cycle after cs, master holds cs until ack.
module rtc_alarm_bank #(
  parameter int NUM_ALARM = 4,
  parameter int AW        = 5
) (
  input  logic                 rtc_clk,
  input  logic                 rst,
  input  logic                 reg_cs,
  input  logic [AW-1:0]        reg_addr,
  input  logic [31:0]          reg_wdata,
  input  logic [3:0]           reg_be,
  input  logic                 reg_wr,
  output logic [31:0]          reg_rdata,
  output logic                 reg_ack,
  input  logic [31:0]          time_bcd,
  input  logic [31:0]          date_bcd,
  input  logic                 inc_time_s,
  output logic [NUM_ALARM-1:0] alarm_hit,
  output logic                 alarm_intr
);

  typedef enum logic [1:0] {DISARMED, ARMED, FIRED} state_t;

  localparam int            IW       = AW - 2;
  localparam logic [AW-1:0] EN_ADDR  = AW'(4 * NUM_ALARM);
  localparam logic [AW-1:0] STS_ADDR = AW'(4 * NUM_ALARM + 1);

  logic                 ack_q;
  logic [31:0]          rdata_q;
  logic                 eval_p;
  logic [NUM_ALARM-1:0] hit_q;
  logic                 intr_q;
  logic [NUM_ALARM-1:0] int_en;
  logic [NUM_ALARM-1:0] int_sts;

  logic [31:0] alm_time [NUM_ALARM];
  logic [31:0] alm_date [NUM_ALARM];
  logic [8:0]  alm_ctrl [NUM_ALARM];
  logic [7:0]  alm_cnt  [NUM_ALARM];
  state_t      state     [NUM_ALARM];
  state_t      state_nxt [NUM_ALARM];
  logic [8:0]  ctrl_new  [NUM_ALARM];

  logic                 acc;
  logic                 wr_go;
  logic [NUM_ALARM-1:0] sel_alm, sel_time, sel_date, sel_ctrl, sel_cnt;
  logic [NUM_ALARM-1:0] match, hit;
  logic [NUM_ALARM-1:0] w1c;
  logic                 en_wr;
  logic [31:0]          rmux;

  function automatic logic [31:0] be_merge(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [3:0] be);
    logic [31:0] res;
    res = old;
    for (int b = 0; b < 4; b++)
      if (be[b]) res[8*b +: 8] = wd[8*b +: 8];
    return res;
  endfunction

  assign acc        = reg_cs & ~ack_q;
  assign wr_go      = acc & reg_wr;
  assign reg_ack    = ack_q;
  assign reg_rdata  = rdata_q;
  assign alarm_hit  = hit_q;
  assign alarm_intr = intr_q;

  assign en_wr = wr_go && (reg_addr == EN_ADDR) && reg_be[0];
  assign w1c   = (wr_go && (reg_addr == STS_ADDR) && reg_be[0]) ? reg_wdata[NUM_ALARM-1:0] : '0;

  // Compare uses the registered CTRL/state, so a same-cycle CTRL write only affects the next tick.
  always_comb begin
    for (int i = 0; i < NUM_ALARM; i++) begin
      sel_alm[i]  = wr_go && (reg_addr[AW-1:2] == IW'(i));
      sel_time[i] = sel_alm[i] && (reg_addr[1:0] == 2'd0);
      sel_date[i] = sel_alm[i] && (reg_addr[1:0] == 2'd1);
      sel_ctrl[i] = sel_alm[i] && (reg_addr[1:0] == 2'd2);
      sel_cnt[i]  = sel_alm[i] && (reg_addr[1:0] == 2'd3);
      match[i] = (!alm_ctrl[i][2] || (time_bcd[7:0]   == alm_time[i][7:0]))   &&
                 (!alm_ctrl[i][3] || (time_bcd[15:8]  == alm_time[i][15:8]))  &&
                 (!alm_ctrl[i][4] || (time_bcd[23:16] == alm_time[i][23:16])) &&
                 (!alm_ctrl[i][5] || (time_bcd[31:24] == alm_time[i][31:24])) &&
                 (!alm_ctrl[i][6] || (date_bcd[7:0]   == alm_date[i][7:0]))   &&
                 (!alm_ctrl[i][7] || (date_bcd[15:8]  == alm_date[i][15:8]))  &&
                 (!alm_ctrl[i][8] || (date_bcd[31:16] == alm_date[i][31:16]));
      hit[i] = eval_p && (state[i] == ARMED) && match[i];
      ctrl_new[i] = {reg_be[1] ? reg_wdata[8]   : alm_ctrl[i][8],
                     reg_be[0] ? reg_wdata[7:0] : alm_ctrl[i][7:0]};
      state_nxt[i] = state[i];
      if (sel_ctrl[i])
        state_nxt[i] = ctrl_new[i][0] ? ARMED : DISARMED;
      else if (hit[i] && !alm_ctrl[i][1])
        state_nxt[i] = FIRED;
    end
  end

  always_comb begin
    rmux = '0;
    for (int i = 0; i < NUM_ALARM; i++) begin
      if (reg_addr[AW-1:2] == IW'(i)) begin
        case (reg_addr[1:0])
          2'd0: rmux = alm_time[i];
          2'd1: rmux = alm_date[i];
          2'd2: rmux = {23'd0, alm_ctrl[i]};
          default: rmux = {24'd0, alm_cnt[i]};
        endcase
      end
    end
    if (reg_addr == EN_ADDR)  rmux = 32'(int_en);
    if (reg_addr == STS_ADDR) rmux = 32'(int_sts);
  end

  always_ff @(posedge rtc_clk) begin
    for (int i = 0; i < NUM_ALARM; i++)
      state[i] <= rst ? DISARMED : state_nxt[i];
  end

  always_ff @(posedge rtc_clk) begin
    if (rst) begin
      ack_q   <= 1'b0;
      rdata_q <= '0;
      eval_p  <= 1'b0;
      hit_q   <= '0;
      intr_q  <= 1'b0;
      int_en  <= '0;
      int_sts <= '0;
      for (int i = 0; i < NUM_ALARM; i++) begin
        alm_time[i] <= '0;
        alm_date[i] <= '0;
        alm_ctrl[i] <= '0;
        alm_cnt[i]  <= '0;
      end
    end else begin
      ack_q   <= acc;
      rdata_q <= (acc && !reg_wr) ? rmux : '0;
      eval_p  <= inc_time_s;
      hit_q   <= hit;
      intr_q  <= |(int_sts & int_en);
      if (en_wr) int_en <= reg_wdata[NUM_ALARM-1:0];
      // A hit in the same cycle as its W1C leaves the status bit set.
      int_sts <= (int_sts & ~w1c) | hit;
      for (int i = 0; i < NUM_ALARM; i++) begin
        if (sel_time[i]) alm_time[i] <= be_merge(alm_time[i], reg_wdata, reg_be);
        if (sel_date[i]) alm_date[i] <= be_merge(alm_date[i], reg_wdata, reg_be);
        if (sel_ctrl[i]) alm_ctrl[i] <= ctrl_new[i];
        if (sel_cnt[i])
          alm_cnt[i] <= hit[i] ? 8'd1 : 8'd0;
        else if (hit[i] && alm_cnt[i] != 8'hFF)
          alm_cnt[i] <= alm_cnt[i] + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_rtc_alarm_bank.sv
// Directed bench for rtc_alarm_bank: vector table for one-shot ticks plus hand sequences for collisions and reset.
module tb_rtc_alarm_bank;

  localparam int N  = 4;
  localparam int AW = 5;

  logic          rtc_clk = 1'b0;
  logic          rst = 1'b1;
  logic          reg_cs = 1'b0;
  logic [AW-1:0] reg_addr = '0;
  logic [31:0]   reg_wdata = '0;
  logic [3:0]    reg_be = '0;
  logic          reg_wr = 1'b0;
  logic [31:0]   reg_rdata;
  logic          reg_ack;
  logic [31:0]   time_bcd = '0;
  logic [31:0]   date_bcd = '0;
  logic          inc_time_s = 1'b0;
  logic [N-1:0]  alarm_hit;
  logic          alarm_intr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 rtc_clk = ~rtc_clk;

  rtc_alarm_bank #(.NUM_ALARM(N), .AW(AW)) dut (
    .rtc_clk(rtc_clk), .rst(rst),
    .reg_cs(reg_cs), .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_be(reg_be),
    .reg_wr(reg_wr), .reg_rdata(reg_rdata), .reg_ack(reg_ack),
    .time_bcd(time_bcd), .date_bcd(date_bcd), .inc_time_s(inc_time_s),
    .alarm_hit(alarm_hit), .alarm_intr(alarm_intr)
  );

  typedef struct {
    logic [31:0] t;
    logic [31:0] d;
    logic [3:0]  exp_hit;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic acc(input bit wr, input logic [AW-1:0] a, input logic [31:0] wd,
                     input logic [3:0] be, output logic [31:0] rd, output int lat);
    @(posedge rtc_clk); #1;
    reg_cs = 1'b1; reg_wr = wr; reg_addr = a; reg_wdata = wd; reg_be = be;
    lat = 0; rd = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge rtc_clk); #1;
      if (reg_ack) begin
        lat = c; rd = reg_rdata;
        break;
      end
    end
    reg_cs = 1'b0; reg_wr = 1'b0;
    if (lat == 0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: addr %0d got no ack expected ack within 8 cycles", a);
    end
  endtask

  task automatic wr_reg(input logic [AW-1:0] a, input logic [31:0] wd);
    logic [31:0] rd; int lat;
    acc(1'b1, a, wd, 4'hF, rd, lat);
  endtask

  task automatic rd_reg(input logic [AW-1:0] a, output logic [31:0] rd);
    int lat;
    acc(1'b0, a, 32'h0, 4'h0, rd, lat);
  endtask

  // One seconds tick; collects alarm_hit over the following three cycles.
  task automatic tick(input logic [31:0] t, input logic [31:0] d,
                      output logic [N-1:0] hits, output int first);
    @(posedge rtc_clk); #1;
    time_bcd = t; date_bcd = d; inc_time_s = 1'b1;
    hits = '0; first = -1;
    for (int c = 1; c <= 3; c++) begin
      @(posedge rtc_clk); #1;
      if (c == 1) inc_time_s = 1'b0;
      if (alarm_hit != '0 && first < 0) first = c;
      hits |= alarm_hit;
    end
  endtask

  // Tick whose eval cycle coincides with the acked write's commit edge.
  task automatic tick_wr(input logic [31:0] t, input logic [AW-1:0] a, input logic [31:0] wd,
                         output logic [N-1:0] hit_at_ack, output logic ack_seen);
    @(posedge rtc_clk); #1;
    time_bcd = t; inc_time_s = 1'b1;
    @(posedge rtc_clk); #1;
    inc_time_s = 1'b0;
    reg_cs = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = wd; reg_be = 4'hF;
    @(posedge rtc_clk); #1;
    ack_seen = reg_ack; hit_at_ack = alarm_hit;
    reg_cs = 1'b0; reg_wr = 1'b0;
    @(posedge rtc_clk); #1;
  endtask

  function automatic logic [7:0] bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tv [4];
    logic [31:0] rd;
    logic [N-1:0] h;
    logic        ack_s;
    int          first, lat, n0, n1;
    logic [31:0] day = 32'h2024_0315;

    tv[0] = '{t: 32'h0112_3004, d: day,          exp_hit: 4'b0000};
    tv[1] = '{t: 32'h0112_3005, d: day,          exp_hit: 4'b0001};
    tv[2] = '{t: 32'h0112_3006, d: day,          exp_hit: 4'b0000};
    tv[3] = '{t: 32'h0212_3005, d: 32'h2024_0316, exp_hit: 4'b0000};

    // Reset
    repeat (2) @(posedge rtc_clk);
    #1;
    chk("rst_ack", 32'(reg_ack), 0);
    chk("rst_rdata", reg_rdata, 0);
    chk("rst_hit", 32'(alarm_hit), 0);
    chk("rst_intr", 32'(alarm_intr), 0);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      rd_reg(AW'(a), rd);
      chk($sformatf("rst_read_%0d", a), rd, 0);
    end

    // One-shot alarm 0 at 12:30:05
    wr_reg(5'd0, 32'h0012_3005);
    wr_reg(5'd2, 32'h0000_001D);
    wr_reg(5'd16, 32'h1);
    for (int v = 0; v < 4; v++) begin
      tick(tv[v].t, tv[v].d, h, first);
      chk($sformatf("oneshot_hit_v%0d", v), 32'(h), 32'(tv[v].exp_hit));
      if (tv[v].exp_hit != 0) chk("oneshot_latency", 32'(first), 2);
    end
    chk("oneshot_intr", 32'(alarm_intr), 1);
    rd_reg(5'd3, rd);  chk("oneshot_cnt", rd, 1);
    rd_reg(5'd17, rd); chk("oneshot_sts", rd, 1);
    wr_reg(5'd2, 32'h0000_001D);
    tick(32'h0312_3005, 32'h2024_0317, h, first);
    chk("rearm_hit", 32'(h), 1);
    rd_reg(5'd3, rd);  chk("rearm_cnt", rd, 2);

    // Repeat alarm 1 on second 30
    wr_reg(5'd4, 32'h0000_0030);
    wr_reg(5'd6, 32'h0000_0007);
    wr_reg(5'd16, 32'h3);
    n0 = 0; n1 = 0;
    for (int m = 31; m <= 33; m++)
      for (int s = 0; s < 60; s++) begin
        tick({8'h01, 8'h12, bcd(m), bcd(s)}, day, h, first);
        n0 += int'(h[0]);
        n1 += int'(h[1]);
      end
    chk("repeat_hits1", 32'(n1), 3);
    chk("repeat_hits0", 32'(n0), 0);
    rd_reg(5'd7, rd);  chk("repeat_cnt", rd, 3);
    rd_reg(5'd17, rd); chk("repeat_sts", rd, 3);
    wr_reg(5'd17, 32'h1);
    @(posedge rtc_clk); #1;
    chk("w1c0_intr_held", 32'(alarm_intr), 1);
    wr_reg(5'd17, 32'h2);
    chk("w1c1_intr_ackcycle", 32'(alarm_intr), 1);
    @(posedge rtc_clk); #1;
    chk("w1c1_intr_drop", 32'(alarm_intr), 0);

    // Collisions on alarm 2 (no mask, repeat)
    wr_reg(5'd8, 32'h0);
    wr_reg(5'd10, 32'h3);
    tick_wr(32'h0112_3400, 5'd17, 32'h4, h, ack_s);
    chk("coll_sts_ack", 32'(ack_s), 1);
    chk("coll_sts_hit", 32'(h), 32'h4);
    rd_reg(5'd17, rd); chk("coll_sts_kept", rd, 32'h4);
    rd_reg(5'd11, rd); chk("coll_cnt_first", rd, 1);
    tick_wr(32'h0112_3400, 5'd11, 32'h0, h, ack_s);
    chk("coll_cnt_ack", 32'(ack_s), 1);
    rd_reg(5'd11, rd); chk("coll_cnt_one", rd, 1);
    for (int k = 0; k < 260; k++) tick(32'h0112_3400, day, h, first);
    rd_reg(5'd11, rd); chk("cnt_saturate", rd, 32'hFF);

    // Handshake and byte enables
    acc(1'b1, 5'd12, 32'hAABB_CCDD, 4'b0101, rd, lat);
    chk("hs_latency", 32'(lat), 1);
    @(posedge rtc_clk); #1;
    chk("hs_ack_width", 32'(reg_ack), 0);
    chk("hs_rdata_idle", reg_rdata, 0);
    rd_reg(5'd12, rd); chk("be_merge", rd, 32'h00BB_00DD);
    acc(1'b1, 5'd18, 32'hFFFF_FFFF, 4'hF, rd, lat);
    chk("unmapped_wr_ack", 32'(lat), 1);
    acc(1'b0, 5'd18, 32'h0, 4'h0, rd, lat);
    chk("unmapped_rd_ack", 32'(lat), 1);
    chk("unmapped_rd", rd, 0);

    // Reset mid-operation
    wr_reg(5'd14, 32'h1);
    @(posedge rtc_clk); #1;
    reg_cs = 1'b1; reg_wr = 1'b0; reg_addr = 5'd3; rst = 1'b1;
    @(posedge rtc_clk); #1;
    chk("midrst_ack0", 32'(reg_ack), 0);
    @(posedge rtc_clk); #1;
    chk("midrst_ack1", 32'(reg_ack), 0);
    rst = 1'b0; reg_cs = 1'b0;
    @(posedge rtc_clk); #1;
    chk("midrst_ack2", 32'(reg_ack), 0);
    chk("midrst_intr", 32'(alarm_intr), 0);
    tick(32'h0112_3400, day, h, first);
    chk("midrst_disarmed", 32'(h), 0);
    rd_reg(5'd11, rd); chk("midrst_cnt", rd, 0);
    rd_reg(5'd14, rd); chk("midrst_ctrl", rd, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
